// File: rtl/btb_update_ctrl_pkg.sv
// Shared types and default sizing for the BTB update path.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package btb_update_ctrl_pkg;

    typedef logic [15:0] lc3b_word;

    // One pending BTB write: the branch PC (index/tag) and its resolved target.
    typedef struct packed {
        lc3b_word pc;
        lc3b_word target;
    } lc3b_btb_upd;

    localparam int BTB_UPD_DEPTH = 4;
    localparam int BTB_MAX_DEFER = 3;

endpackage

// File: rtl/btb_upd_queue.sv
// Circular buffer of pending BTB updates with an associative PC lookup for coalescing.
// Latency: an entry written at a clock edge is visible at the head the following cycle.
// Backpressure: none internally; the caller must not enqueue when full without a same-cycle dequeue.
module btb_upd_queue
    import btb_update_ctrl_pkg::*;
#(
    parameter int DEPTH = BTB_UPD_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enq_i,
    input  lc3b_btb_upd       enq_dat_i,
    input  logic              deq_i,
    input  logic              coal_i,
    input  logic [PTR_W-1:0]  coal_idx_i,
    input  lc3b_word          coal_target_i,
    input  lc3b_word          match_pc_i,
    output logic              match_vld_o,
    output logic [PTR_W-1:0]  match_idx_o,
    output lc3b_btb_upd       head_dat_o,
    output logic [PTR_W-1:0]  head_idx_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    lc3b_btb_upd         mem_q [DEPTH];
    logic [PTR_W-1:0]    head_q;
    logic [PTR_W-1:0]    tail_q;
    logic [CNT_W-1:0]    count_q;
    logic [DEPTH-1:0]    slot_vld;

    // Storage and pointers; coalesce and enqueue never target the same slot
    // because coalescing only happens when the PC is already present.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (coal_i) begin
                mem_q[coal_idx_i].target <= coal_target_i;
            end
            if (enq_i) begin
                mem_q[tail_q] <= enq_dat_i;
                tail_q        <= tail_q + PTR_W'(1);
            end
            if (deq_i) begin
                head_q <= head_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(enq_i) - CNT_W'(deq_i);
        end
    end

    // Occupancy per slot (distance from head below count) and first PC match.
    always_comb begin
        match_vld_o = 1'b0;
        match_idx_o = '0;
        slot_vld    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_vld[i] = ({1'b0, PTR_W'(PTR_W'(i) - head_q)} < count_q);
            if (slot_vld[i] && (mem_q[i].pc == match_pc_i) && !match_vld_o) begin
                match_vld_o = 1'b1;
                match_idx_o = PTR_W'(i);
            end
        end
    end

    assign head_dat_o = mem_q[head_q];
    assign head_idx_o = head_q;
    assign count_o    = count_q;
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);

endmodule

// File: rtl/btb_update_ctrl.sv
// Filters resolved taken branches, queues/coalesces them and drains one per cycle into the BTB write port.
// Latency: res_valid in cycle N -> btb_write in N+2 when the queue is empty and fetch does not conflict.
// Backpressure: none upstream; candidates arriving to a full queue (after same-cycle issue) are dropped and counted.
module btb_update_ctrl
    import btb_update_ctrl_pkg::*;
#(
    parameter int DEPTH     = BTB_UPD_DEPTH,
    parameter int MAX_DEFER = BTB_MAX_DEFER,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1,
    localparam int DEF_W = $clog2(MAX_DEFER + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              res_valid,
    input  logic [15:0]       res_pc,
    input  logic [15:0]       res_target,
    input  logic              res_taken,
    input  logic              res_pred_hit,
    input  logic [15:0]       res_pred_pc,
    input  logic [15:0]       fetch_pc,
    input  logic              fetch_hit,
    output logic [15:0]       btb_write_pc,
    output logic [15:0]       btb_write_data,
    output logic              btb_write,
    output logic              q_full,
    output logic [CNT_W-1:0]  q_count,
    output logic [15:0]       drop_count
);

    lc3b_btb_upd       head;
    logic [PTR_W-1:0]  head_idx;
    logic [PTR_W-1:0]  match_idx;
    logic              match_vld;
    logic              q_empty;
    logic              cand, coal, enq, drop;
    logic              conflict, forced, issue;

    logic [DEF_W-1:0]  defer_q, defer_d;
    logic              wr_q, wr_d;
    lc3b_word          wr_pc_q, wr_pc_d;
    lc3b_word          wr_data_q, wr_data_d;
    logic [15:0]       drop_q, drop_d;

    // Only the set-index bits of the fetch PC matter for the LRU race.
    logic unused_fetch_bits;
    assign unused_fetch_bits = ^{fetch_pc[15:4], fetch_pc[0]};

    btb_upd_queue #(.DEPTH(DEPTH)) u_queue (
        .clk           (clk),
        .reset         (reset),
        .enq_i         (enq),
        .enq_dat_i     ('{pc: res_pc, target: res_target}),
        .deq_i         (issue),
        .coal_i        (coal),
        .coal_idx_i    (match_idx),
        .coal_target_i (res_target),
        .match_pc_i    (res_pc),
        .match_vld_o   (match_vld),
        .match_idx_o   (match_idx),
        .head_dat_o    (head),
        .head_idx_o    (head_idx),
        .count_o       (q_count),
        .full_o        (q_full),
        .empty_o       (q_empty)
    );

    // Candidate filter, fetch-set conflict and queue control; a dequeue frees
    // its slot for a same-cycle candidate.
    always_comb begin
        cand     = res_valid & res_taken & (~res_pred_hit | (res_pred_pc != res_target));
        coal     = cand & match_vld;
        conflict = fetch_hit & (fetch_pc[3:1] == head.pc[3:1]);
        forced   = (defer_q == DEF_W'(MAX_DEFER));
        issue    = ~q_empty & (~conflict | forced);
        enq      = cand & ~match_vld & (~q_full | issue);
        drop     = cand & ~match_vld & q_full & ~issue;
    end

    // Next state for the defer counter, write-port registers and drop counter.
    always_comb begin
        defer_d   = defer_q;
        wr_d      = issue;
        wr_pc_d   = wr_pc_q;
        wr_data_d = wr_data_q;
        drop_d    = drop_q;
        if (issue) begin
            defer_d = '0;
        end else if (!q_empty && conflict) begin
            defer_d = defer_q + DEF_W'(1);
        end
        if (issue) begin
            wr_pc_d   = head.pc;
            // A coalesce onto the popping head must still reach the BTB.
            wr_data_d = (coal && (match_idx == head_idx)) ? res_target : head.target;
        end
        if (drop && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // Registered state of the controller.
    always_ff @(posedge clk) begin
        if (reset) begin
            defer_q   <= '0;
            wr_q      <= 1'b0;
            wr_pc_q   <= '0;
            wr_data_q <= '0;
            drop_q    <= '0;
        end else begin
            defer_q   <= defer_d;
            wr_q      <= wr_d;
            wr_pc_q   <= wr_pc_d;
            wr_data_q <= wr_data_d;
            drop_q    <= drop_d;
        end
    end

    assign btb_write      = wr_q;
    assign btb_write_pc   = wr_pc_q;
    assign btb_write_data = wr_data_q;
    assign drop_count     = drop_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: per-cycle vector table plus hand sequences.
// Latency: checks outputs on the falling edge after each rising edge.
// Backpressure: exercises full-queue drop, forced issue and coalescing.
module tb_btb_update_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        res_valid, res_taken, res_pred_hit, fetch_hit;
    logic [15:0] res_pc, res_target, res_pred_pc, fetch_pc;
    logic [15:0] btb_write_pc, btb_write_data, drop_count;
    logic        btb_write, q_full;
    logic [2:0]  q_count;

    int n_cmp = 0;
    int n_err = 0;

    btb_update_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .res_valid      (res_valid),
        .res_pc         (res_pc),
        .res_target     (res_target),
        .res_taken      (res_taken),
        .res_pred_hit   (res_pred_hit),
        .res_pred_pc    (res_pred_pc),
        .fetch_pc       (fetch_pc),
        .fetch_hit      (fetch_hit),
        .btb_write_pc   (btb_write_pc),
        .btb_write_data (btb_write_data),
        .btb_write      (btb_write),
        .q_full         (q_full),
        .q_count        (q_count),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [15:0] pc;
        logic [15:0] tgt;
        logic        tk;
        logic        ph;
        logic [15:0] ppc;
        logic        ew;
        logic [15:0] epc;
        logic [15:0] edat;
        logic [2:0]  ecnt;
        logic [15:0] edrop;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ew, input logic [15:0] epc,
                           input logic [15:0] edat, input logic [2:0] ecnt, input logic [15:0] edrop);
        chk({tag, ".btb_write"}, {31'd0, btb_write}, {31'd0, ew});
        if (ew) begin
            chk({tag, ".write_pc"}, {16'd0, btb_write_pc}, {16'd0, epc});
            chk({tag, ".write_data"}, {16'd0, btb_write_data}, {16'd0, edat});
        end
        chk({tag, ".q_count"}, {29'd0, q_count}, {29'd0, ecnt});
        chk({tag, ".q_full"}, {31'd0, q_full}, {31'd0, (ecnt == 3'd4)});
        chk({tag, ".drop_count"}, {16'd0, drop_count}, {16'd0, edrop});
    endtask

    task automatic drive(input logic rv, input logic [15:0] pc, input logic [15:0] tgt,
                         input logic tk, input logic ph, input logic [15:0] ppc,
                         input logic fh, input logic [15:0] fpc);
        res_valid    = rv;
        res_pc       = pc;
        res_target   = tgt;
        res_taken    = tk;
        res_pred_hit = ph;
        res_pred_pc  = ppc;
        fetch_hit    = fh;
        fetch_pc     = fpc;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] pc;

        // Basic filter behaviour, no fetch conflict.
        vecs[0]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 3'd0, 16'd0};
        vecs[1]  = '{1'b1, 16'h3010, 16'h3200, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 3'd1, 16'd0};
        vecs[2]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h3010, 16'h3200, 3'd0, 16'd0};
        vecs[3]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 3'd0, 16'd0};
        vecs[4]  = '{1'b1, 16'h3040, 16'h3200, 1'b1, 1'b1, 16'h3200, 1'b0, 16'h0000, 16'h0000, 3'd0, 16'd0};
        vecs[5]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 3'd0, 16'd0};
        vecs[6]  = '{1'b1, 16'h3020, 16'h3300, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 3'd0, 16'd0};
        vecs[7]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 3'd0, 16'd0};
        vecs[8]  = '{1'b1, 16'h3030, 16'h3400, 1'b1, 1'b1, 16'h3500, 1'b0, 16'h0000, 16'h0000, 3'd1, 16'd0};
        vecs[9]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h3030, 16'h3400, 3'd0, 16'd0};
        vecs[10] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 3'd0, 16'd0};
        vecs[11] = '{1'b0, 16'h3050, 16'h3600, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 3'd0, 16'd0};
        vecs[12] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 3'd0, 16'd0};

        reset = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.write_pc", {16'd0, btb_write_pc}, 32'd0);
        chk("reset.write_data", {16'd0, btb_write_data}, 32'd0);
        chk_out("reset", 1'b0, 16'h0, 16'h0, 3'd0, 16'd0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rv, vecs[i].pc, vecs[i].tgt, vecs[i].tk, vecs[i].ph, vecs[i].ppc, 1'b0, 16'h0);
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].ew, vecs[i].epc, vecs[i].edat, vecs[i].ecnt, vecs[i].edrop);
        end

        // Fill under a persistent same-set fetch hit; forced issue lets the
        // 5th miss in, the 6th is dropped.
        for (int k = 0; k < 4; k++) begin
            pc = 16'h3010 + 16'(k * 16);
            drive(1'b1, pc, pc + 16'h0100, 1'b1, 1'b0, 16'h0, 1'b1, 16'h3000);
            step();
            chk_out($sformatf("fill%0d", k), 1'b0, 16'h0, 16'h0, 3'(k + 1), 16'd0);
        end
        drive(1'b1, 16'h3050, 16'h3150, 1'b1, 1'b0, 16'h0, 1'b1, 16'h3000);
        step();
        chk_out("full_issue_accept", 1'b1, 16'h3010, 16'h3110, 3'd4, 16'd0);
        drive(1'b1, 16'h3060, 16'h3160, 1'b1, 1'b0, 16'h0, 1'b1, 16'h3000);
        step();
        chk_out("full_drop", 1'b0, 16'h0, 16'h0, 3'd4, 16'd1);

        // Drain: each head waits out three deferrals before being forced.
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h3000);
        for (int k = 1; k <= 4; k++) begin
            repeat ((k == 1) ? 2 : 3) begin
                step();
                chk_out($sformatf("defer%0d", k), 1'b0, 16'h0, 16'h0, 3'(5 - k), 16'd1);
            end
            pc = 16'h3010 + 16'(k * 16);
            step();
            chk_out($sformatf("forced%0d", k), 1'b1, pc, pc + 16'h0100, 3'(4 - k), 16'd1);
        end
        step();
        chk_out("drained", 1'b0, 16'h0, 16'h0, 3'd0, 16'd1);

        // Reset with three entries pending.
        for (int k = 0; k < 3; k++) begin
            pc = 16'h3010 + 16'(k * 16);
            drive(1'b1, pc, pc + 16'h0200, 1'b1, 1'b0, 16'h0, 1'b1, 16'h3000);
            step();
        end
        chk("pre_reset.q_count", {29'd0, q_count}, 32'd3);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h3000);
        reset = 1'b1;
        step();
        chk_out("mid_reset", 1'b0, 16'h0, 16'h0, 3'd0, 16'd0);
        reset = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk_out($sformatf("post_reset%0d", k), 1'b0, 16'h0, 16'h0, 3'd0, 16'd0);
        end

        // Coalesce while the head is deferred: one write, newest target.
        drive(1'b1, 16'h3010, 16'h3200, 1'b1, 1'b0, 16'h0, 1'b1, 16'h3000);
        step();
        chk_out("coal_enq", 1'b0, 16'h0, 16'h0, 3'd1, 16'd0);
        drive(1'b1, 16'h3010, 16'h3300, 1'b1, 1'b0, 16'h0, 1'b1, 16'h3000);
        step();
        chk_out("coal_merge", 1'b0, 16'h0, 16'h0, 3'd1, 16'd0);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        step();
        chk_out("coal_write", 1'b1, 16'h3010, 16'h3300, 3'd0, 16'd0);
        step();
        chk_out("coal_single", 1'b0, 16'h0, 16'h0, 3'd0, 16'd0);

        // Coalesce onto the head in the cycle it issues.
        drive(1'b1, 16'h3010, 16'h3200, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        step();
        chk_out("hcoal_enq", 1'b0, 16'h0, 16'h0, 3'd1, 16'd0);
        drive(1'b1, 16'h3010, 16'h3400, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        step();
        chk_out("hcoal_write", 1'b1, 16'h3010, 16'h3400, 3'd0, 16'd0);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        step();
        chk_out("hcoal_idle", 1'b0, 16'h0, 16'h0, 3'd0, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
